// File: rtl/fetch_packet_sender_pkg.sv
// Shared constants, state encoding and payload types for the IF-stage packet sender.
// The optional IF_PRED_TRUNC_EN build switch is consumed by the sender and its slot mask.
package fetch_packet_sender_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned SLOTS              = 4;
    localparam int unsigned LINE_W             = SLOTS * XLEN;
    localparam int unsigned EXCCODE_W          = 5;
    localparam int unsigned ALL_CHECKPOINT_LEN = 8;

    localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'h04;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic                 has_exception;
        logic [EXCCODE_W-1:0] exc_code;
        logic                 is_refill;
    } exc_info_t;

    // Thermometer mask with the lowest cnt bits set (cnt in 0..4).
    function automatic logic [SLOTS-1:0] therm(input logic [2:0] cnt);
        logic [SLOTS-1:0] t;
        t = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (3'(i) < cnt) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/fetch_packet_sender_if.sv
// IF-stage bus bundle: queue back-pressure, backend redirect, I-cache, predictor and packet output.
interface fetch_packet_sender_if
    import fetch_packet_sender_pkg::*;
#(
    parameter int unsigned CKPT_W = ALL_CHECKPOINT_LEN
) ();

    logic                       ID_stopFetch_i;
    logic                       BE_redirect_i;
    logic [XLEN-1:0]            BE_redirectPC_i;

    logic                       IC_req_o;
    logic [XLEN-1:0]            IC_addr_o;
    logic                       IC_ready_i;
    logic                       IC_respValid_i;
    logic [LINE_W-1:0]          IC_data_i;
    logic                       IC_hasException_i;
    logic [EXCCODE_W-1:0]       IC_ExcCode_i;
    logic                       IC_isRefill_i;

    logic [SLOTS-1:0]           BP_predTake_i;
    logic [LINE_W-1:0]          BP_predDest_i;
    logic [SLOTS*CKPT_W-1:0]    BP_predInfo_i;

    logic                       IF_valid_o;
    logic [SLOTS-1:0]           IF_instEnable_o;
    logic [2:0]                 IF_instNum_o;
    logic [XLEN-1:0]            IF_instBasePC_o;
    logic [LINE_W-1:0]          IF_inst_p_o;
    logic [LINE_W-1:0]          IF_predDest_p_o;
    logic [SLOTS-1:0]           IF_predTake_p_o;
    logic [SLOTS*CKPT_W-1:0]    IF_predInfo_p_o;
    logic                       IF_hasException_o;
    logic [EXCCODE_W-1:0]       IF_ExcCode_o;
    logic                       IF_isRefill_o;

    modport master (
        input  ID_stopFetch_i, BE_redirect_i, BE_redirectPC_i,
        output IC_req_o, IC_addr_o,
        input  IC_ready_i, IC_respValid_i, IC_data_i, IC_hasException_i, IC_ExcCode_i, IC_isRefill_i,
        input  BP_predTake_i, BP_predDest_i, BP_predInfo_i,
        output IF_valid_o, IF_instEnable_o, IF_instNum_o, IF_instBasePC_o, IF_inst_p_o,
        output IF_predDest_p_o, IF_predTake_p_o, IF_predInfo_p_o,
        output IF_hasException_o, IF_ExcCode_o, IF_isRefill_o
    );

    modport slave (
        output ID_stopFetch_i, BE_redirect_i, BE_redirectPC_i,
        input  IC_req_o, IC_addr_o,
        output IC_ready_i, IC_respValid_i, IC_data_i, IC_hasException_i, IC_ExcCode_i, IC_isRefill_i,
        output BP_predTake_i, BP_predDest_i, BP_predInfo_i,
        input  IF_valid_o, IF_instEnable_o, IF_instNum_o, IF_instBasePC_o, IF_inst_p_o,
        input  IF_predDest_p_o, IF_predTake_p_o, IF_predInfo_p_o,
        input  IF_hasException_o, IF_ExcCode_o, IF_isRefill_o
    );

endinterface

// File: rtl/fetch_slot_mask.sv
// Combinational slot selection for one fetch line: valid-slot thermometer, count, first taken slot.
// Prediction truncation and delay-slot handling only exist when IF_PRED_TRUNC_EN is defined.
module fetch_slot_mask
    import fetch_packet_sender_pkg::*;
(
    input  logic [1:0]       pc_slot_i,
    input  logic [SLOTS-1:0] pred_take_i,
    input  logic             dly_pend_i,
    output logic [SLOTS-1:0] enable_c,
    output logic [2:0]       num_c,
    output logic [1:0]       k_c,
    output logic             take_c,
    output logic             dly_needed_c
);

    logic [2:0] base_num;

    always_comb begin
        base_num     = 3'(SLOTS) - 3'(pc_slot_i);
        enable_c     = therm(base_num);
        num_c        = base_num;
        k_c          = '0;
        take_c       = 1'b0;
        dly_needed_c = 1'b0;
`ifdef IF_PRED_TRUNC_EN
        if (dly_pend_i) begin
            // Delay-slot packet: only the branch's delay slot, predictions ignored.
            enable_c = 4'b0001;
            num_c    = 3'd1;
        end else begin
            // Scan downward so the lowest taken slot inside the line wins.
            for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
                if (pred_take_i[i] && (3'(i) < base_num)) begin
                    k_c    = 2'(i);
                    take_c = 1'b1;
                end
            end
            if (take_c) begin
                if (3'(k_c) == base_num - 3'd1) begin
                    dly_needed_c = 1'b1;
                end else begin
                    num_c    = 3'(k_c) + 3'd2;
                    enable_c = therm(num_c);
                end
            end
        end
`endif
    end

`ifndef IF_PRED_TRUNC_EN
    logic unused_pred_in;
    assign unused_pred_in = ^{pred_take_i, dly_pend_i};
`endif

endmodule

// File: rtl/fetch_packet_sender.sv
// IF-stage fetch PC owner: one I-cache line request at a time, one registered packet per response.
// Build switch IF_PRED_TRUNC_EN enables predictor-driven truncation, redirect and delay-slot handling.
module fetch_packet_sender
    import fetch_packet_sender_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned     CKPT_W   = ALL_CHECKPOINT_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_packet_sender_if.master bus
);

    localparam int unsigned INFO_W = SLOTS * CKPT_W;

    fetch_state_e        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                dly_pend_q, dly_pend_d;
    logic [XLEN-1:0]     dly_tgt_q, dly_tgt_d;
    logic                valid_q, valid_d;
    logic [SLOTS-1:0]    enable_q, enable_d;
    logic [2:0]          num_q, num_d;
    logic [XLEN-1:0]     base_pc_q, base_pc_d;
    logic [LINE_W-1:0]   inst_q, inst_d;
    logic [SLOTS-1:0]    pred_take_q, pred_take_d;
    logic [LINE_W-1:0]   pred_dest_q, pred_dest_d;
    logic [INFO_W-1:0]   pred_info_q, pred_info_d;
    exc_info_t           exc_q, exc_d;

    logic [SLOTS-1:0]    slot_enable_c;
    logic [2:0]          slot_num_c;
    logic [1:0]          slot_k_c;
    logic                slot_take_c;
    logic                slot_dly_needed_c;
    logic                req_c;
    logic [XLEN-1:0]     next_line_c;

    fetch_slot_mask u_slot_mask (
        .pc_slot_i    (pc_q[3:2]),
        .pred_take_i  (bus.BP_predTake_i),
        .dly_pend_i   (dly_pend_q),
        .enable_c     (slot_enable_c),
        .num_c        (slot_num_c),
        .k_c          (slot_k_c),
        .take_c       (slot_take_c),
        .dly_needed_c (slot_dly_needed_c)
    );

    assign next_line_c = {pc_q[XLEN-1:4] + 28'd1, 4'h0};
    assign req_c = rst && (state_q == S_REQ) && !bus.ID_stopFetch_i && !bus.BE_redirect_i
                   && (pc_q[1:0] == 2'b00);

`ifdef IF_PRED_TRUNC_EN
    logic [XLEN-1:0]   dest_sel_c;
    logic [LINE_W-1:0] dest_mask_c;
    logic [INFO_W-1:0] info_mask_c;

    // Per-slot masks so predictor fields of disabled slots read as zero.
    always_comb begin
        dest_sel_c  = 32'(bus.BP_predDest_i >> {slot_k_c, 5'b0_0000});
        dest_mask_c = '0;
        info_mask_c = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            dest_mask_c[i*XLEN +: XLEN]     = {XLEN{slot_enable_c[i]}};
            info_mask_c[i*CKPT_W +: CKPT_W] = {CKPT_W{slot_enable_c[i]}};
        end
    end
`else
    logic unused_pred;
    assign unused_pred = ^{bus.BP_predDest_i, bus.BP_predInfo_i, slot_k_c, slot_take_c,
                           slot_dly_needed_c};
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dly_pend_d  = dly_pend_q;
        dly_tgt_d   = dly_tgt_q;
        valid_d     = 1'b0;
        enable_d    = enable_q;
        num_d       = num_q;
        base_pc_d   = base_pc_q;
        inst_d      = inst_q;
        pred_take_d = pred_take_q;
        pred_dest_d = pred_dest_q;
        pred_info_d = pred_info_q;
        exc_d       = exc_q;

        if (bus.BE_redirect_i) begin
            // Redirect wins everywhere; an in-flight line must still be absorbed in S_DROP.
            pc_d       = bus.BE_redirectPC_i;
            dly_pend_d = 1'b0;
            if ((state_q == S_WAIT || state_q == S_DROP) && !bus.IC_respValid_i) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (pc_q[1:0] != 2'b00) begin
                        valid_d     = 1'b1;
                        enable_d    = 4'b0001;
                        num_d       = 3'd1;
                        base_pc_d   = pc_q;
                        inst_d      = '0;
                        pred_take_d = '0;
                        pred_dest_d = '0;
                        pred_info_d = '0;
                        exc_d       = '{has_exception: 1'b1, exc_code: EXC_ADEL, is_refill: 1'b0};
                        state_d     = S_HALT;
                    end else if (req_c && bus.IC_ready_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.IC_respValid_i) begin
                        valid_d     = 1'b1;
                        base_pc_d   = pc_q;
                        inst_d      = bus.IC_data_i;
                        pred_take_d = '0;
                        pred_dest_d = '0;
                        pred_info_d = '0;
                        state_d     = S_REQ;
                        if (bus.IC_hasException_i) begin
                            enable_d = 4'b0001;
                            num_d    = 3'd1;
                            exc_d    = '{has_exception: 1'b1, exc_code: bus.IC_ExcCode_i,
                                         is_refill: bus.IC_isRefill_i};
                            state_d  = S_HALT;
                        end else begin
                            enable_d = slot_enable_c;
                            num_d    = slot_num_c;
                            exc_d    = '0;
`ifdef IF_PRED_TRUNC_EN
                            pred_take_d = dly_pend_q ? '0 : (bus.BP_predTake_i & slot_enable_c);
                            pred_dest_d = bus.BP_predDest_i & dest_mask_c;
                            pred_info_d = bus.BP_predInfo_i & info_mask_c;
                            if (dly_pend_q) begin
                                pc_d       = dly_tgt_q;
                                dly_pend_d = 1'b0;
                            end else if (slot_take_c && !slot_dly_needed_c) begin
                                pc_d = dest_sel_c;
                            end else begin
                                pc_d = next_line_c;
                                if (slot_dly_needed_c) begin
                                    dly_pend_d = 1'b1;
                                    dly_tgt_d  = dest_sel_c;
                                end
                            end
`else
                            pc_d = next_line_c;
`endif
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                S_DROP: begin
                    if (bus.IC_respValid_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            dly_pend_q  <= 1'b0;
            dly_tgt_q   <= '0;
            valid_q     <= 1'b0;
            enable_q    <= '0;
            num_q       <= '0;
            base_pc_q   <= '0;
            inst_q      <= '0;
            pred_take_q <= '0;
            pred_dest_q <= '0;
            pred_info_q <= '0;
            exc_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dly_pend_q  <= dly_pend_d;
            dly_tgt_q   <= dly_tgt_d;
            valid_q     <= valid_d;
            enable_q    <= enable_d;
            num_q       <= num_d;
            base_pc_q   <= base_pc_d;
            inst_q      <= inst_d;
            pred_take_q <= pred_take_d;
            pred_dest_q <= pred_dest_d;
            pred_info_q <= pred_info_d;
            exc_q       <= exc_d;
        end
    end

    assign bus.IC_req_o          = req_c;
    assign bus.IC_addr_o         = pc_q;
    assign bus.IF_valid_o        = valid_q;
    assign bus.IF_instEnable_o   = enable_q;
    assign bus.IF_instNum_o      = num_q;
    assign bus.IF_instBasePC_o   = base_pc_q;
    assign bus.IF_inst_p_o       = inst_q;
    assign bus.IF_predTake_p_o   = pred_take_q;
    assign bus.IF_predDest_p_o   = pred_dest_q;
    assign bus.IF_predInfo_p_o   = pred_info_q;
    assign bus.IF_hasException_o = exc_q.has_exception;
    assign bus.IF_ExcCode_o      = exc_q.exc_code;
    assign bus.IF_isRefill_o     = exc_q.is_refill;

endmodule

// File: tb/tb_fetch_packet_sender.sv
// Scoreboard bench for fetch_packet_sender: expected packets queued as responses are driven,
// popped when IF_valid_o is seen. Expectations follow IF_PRED_TRUNC_EN when it is defined.
`timescale 1ns/1ps
module tb_fetch_packet_sender;
    import fetch_packet_sender_pkg::*;

    localparam int unsigned CKPT_W = ALL_CHECKPOINT_LEN;
    localparam int unsigned INFO_W = SLOTS * CKPT_W;
`ifdef IF_PRED_TRUNC_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_packet_sender_if #(.CKPT_W(CKPT_W)) bus ();

    fetch_packet_sender #(.RESET_PC(32'hBFC0_0000), .CKPT_W(CKPT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]        en;
        logic [2:0]        num;
        logic [31:0]       base;
        logic [127:0]      inst;
        logic [3:0]        take;
        logic [127:0]      dest;
        logic [INFO_W-1:0] info;
        logic              exc;
        logic [4:0]        code;
        logic              refill;
    } pkt_t;

    pkt_t        exp_q[$];
    pkt_t        mon_pkt;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_pc;
    logic        m_dly;
    logic [31:0] m_tgt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] data_for(input logic [31:0] pc);
        logic [127:0] r;
        logic [1:0]   s;
        for (int i = 0; i < 4; i++) begin
            s = pc[3:2] + 2'(i);
            r[i*32 +: 32] = {pc[31:4], s, 2'b00} ^ 32'h5A5A_0F0F;
        end
        return r;
    endfunction

    // Packet monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.IF_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 128'(bus.IF_valid_o), 128'd0);
                end else begin
                    mon_pkt = exp_q.pop_front();
                    check("enable",  128'(bus.IF_instEnable_o),   128'(mon_pkt.en));
                    check("num",     128'(bus.IF_instNum_o),      128'(mon_pkt.num));
                    check("base_pc", 128'(bus.IF_instBasePC_o),   128'(mon_pkt.base));
                    check("inst",    bus.IF_inst_p_o,             mon_pkt.inst);
                    check("p_take",  128'(bus.IF_predTake_p_o),   128'(mon_pkt.take));
                    check("p_dest",  bus.IF_predDest_p_o,         mon_pkt.dest);
                    check("p_info",  128'(bus.IF_predInfo_p_o),   128'(mon_pkt.info));
                    check("exc",     128'(bus.IF_hasException_o), 128'(mon_pkt.exc));
                    check("exccode", 128'(bus.IF_ExcCode_o),      128'(mon_pkt.code));
                    check("refill",  128'(bus.IF_isRefill_o),     128'(mon_pkt.refill));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one response for the line at m_pc and queue the packet it must produce.
    task automatic drive_resp(input logic [3:0] take, input logic [127:0] dest, input bit exc,
                              input logic [4:0] code, input bit refill);
        pkt_t              e;
        int                n;
        bit                found;
        bit                dly_pkt;
        logic [31:0]       npc;
        logic [INFO_W-1:0] info;
        logic [127:0]      data;
        data = data_for(m_pc);
        info = INFO_W'({$urandom, $urandom});
        bus.IC_respValid_i    = 1'b1;
        bus.IC_data_i         = data;
        bus.IC_hasException_i = exc;
        bus.IC_ExcCode_i      = code;
        bus.IC_isRefill_i     = refill;
        bus.BP_predTake_i     = take;
        bus.BP_predDest_i     = dest;
        bus.BP_predInfo_i     = info;
        e.base = m_pc;
        e.inst = data;
        e.take = '0;
        e.dest = '0;
        e.info = '0;
        e.exc  = exc;
        e.code = exc ? code : 5'd0;
        e.refill = exc ? refill : 1'b0;
        dly_pkt = PRED_EN && m_dly;
        if (exc) begin
            e.en = 4'b0001;
        end else begin
            n    = 4 - int'(m_pc[3:2]);
            e.en = 4'((1 << n) - 1);
            if (dly_pkt) begin
                e.en  = 4'b0001;
                m_pc  = m_tgt;
                m_dly = 1'b0;
            end else begin
                npc   = {m_pc[31:4] + 28'd1, 4'h0};
                found = 1'b0;
                for (int i = 0; i < n; i++) begin
                    if (PRED_EN && !found && take[i]) begin
                        found = 1'b1;
                        if (i == n - 1) begin
                            m_dly = 1'b1;
                            m_tgt = dest[i*32 +: 32];
                        end else begin
                            e.en = 4'((1 << (i + 2)) - 1);
                            npc  = dest[i*32 +: 32];
                        end
                    end
                end
                m_pc = npc;
            end
            for (int i = 0; i < 4; i++) begin
                if (PRED_EN && e.en[i]) begin
                    if (!dly_pkt) e.take[i] = take[i];
                    e.dest[i*32 +: 32]         = dest[i*32 +: 32];
                    e.info[i*CKPT_W +: CKPT_W] = info[i*CKPT_W +: CKPT_W];
                end
            end
        end
        e.num = 3'($countones(e.en));
        exp_q.push_back(e);
    endtask

    task automatic end_resp();
        bus.IC_respValid_i    = 1'b0;
        bus.IC_hasException_i = 1'b0;
        bus.IC_ExcCode_i      = '0;
        bus.IC_isRefill_i     = 1'b0;
        bus.BP_predTake_i     = '0;
        bus.BP_predDest_i     = '0;
        bus.BP_predInfo_i     = '0;
    endtask

    task automatic wait_req(output bit ok);
        int c;
        ok = 1'b0;
        c  = 0;
        while (!ok && c < 40) begin
            @(negedge clk);
            ok = (bus.IC_req_o === 1'b1);
            c++;
        end
        if (!ok) check("req_timeout", 128'(bus.IC_req_o), 128'd1);
    endtask

    task automatic accept_req(output bit ok);
        wait_req(ok);
        if (ok) begin
            check("req_addr", 128'(bus.IC_addr_o), 128'(m_pc));
            bus.IC_ready_i = 1'b1;
            @(negedge clk);
            bus.IC_ready_i = 1'b0;
        end
    endtask

    task automatic fetch(input logic [3:0] take, input logic [127:0] dest, input int lat,
                         input bit exc, input logic [4:0] code, input bit refill);
        bit ok;
        accept_req(ok);
        if (ok) begin
            repeat (lat) @(negedge clk);
            drive_resp(take, dest, exc, code, refill);
            @(negedge clk);
            end_resp();
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.BE_redirect_i   = 1'b1;
        bus.BE_redirectPC_i = tgt;
        @(negedge clk);
        bus.BE_redirect_i   = 1'b0;
        m_pc  = tgt;
        m_dly = 1'b0;
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check(tag, 128'(bus.IC_req_o), 128'd0);
        end
    endtask

    initial begin
        bit   ok;
        pkt_t a;
        bus.ID_stopFetch_i  = 1'b0;
        bus.BE_redirect_i   = 1'b0;
        bus.BE_redirectPC_i = '0;
        bus.IC_ready_i      = 1'b0;
        end_resp();
        bus.IC_data_i       = '0;
        m_pc  = 32'hBFC0_0000;
        m_dly = 1'b0;
        m_tgt = '0;

        repeat (3) @(negedge clk);
        check("rst_valid",  128'(bus.IF_valid_o),        128'd0);
        check("rst_enable", 128'(bus.IF_instEnable_o),   128'd0);
        check("rst_num",    128'(bus.IF_instNum_o),      128'd0);
        check("rst_req",    128'(bus.IC_req_o),          128'd0);
        check("rst_addr",   128'(bus.IC_addr_o),         128'h0BFC0_0000);
        check("rst_exc",    128'(bus.IF_hasException_o), 128'd0);
        rst = 1'b1;

        // Straight-line and offset fetches, then predictor-driven cases.
        fetch(4'b0000, '0, 1, 1'b0, 5'd0, 1'b0);
        redirect(32'h8000_0008);
        fetch(4'b0000, '0, 0, 1'b0, 5'd0, 1'b0);
        fetch(4'b0010, {32'h0, 32'h0, 32'h9000_0000, 32'h0}, 2, 1'b0, 5'd0, 1'b0);
        fetch(4'b1000, {32'hA000_0040, 96'h0}, 1, 1'b0, 5'd0, 1'b0);
        fetch(4'b1111, {4{32'h1234_5678}}, 0, 1'b0, 5'd0, 1'b0);
        fetch(4'b0000, '0, 1, 1'b0, 5'd0, 1'b0);
        redirect(32'hC000_000C);
        fetch(4'b0010, {32'h0, 32'h0, 32'hDEAD_0000, 32'h0}, 1, 1'b0, 5'd0, 1'b0);
        redirect(32'hC000_0104);
        fetch(4'b0001, {96'h0, 32'hC000_0200}, 0, 1'b0, 5'd0, 1'b0);

        // Redirect while a line is outstanding: its response must be dropped.
        accept_req(ok);
        redirect(32'h8000_1000);
        check("drop_req", 128'(bus.IC_req_o), 128'd0);
        bus.IC_respValid_i = 1'b1;
        bus.IC_data_i      = data_for(32'hFFFF_FFF0);
        @(negedge clk);
        end_resp();
        check("drop_valid", 128'(bus.IF_valid_o), 128'd0);
        fetch(4'b0000, '0, 1, 1'b0, 5'd0, 1'b0);

        // Back-pressure: no requests, outstanding packet still delivered.
        accept_req(ok);
        bus.ID_stopFetch_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stop_req", 128'(bus.IC_req_o), 128'd0);
            if (c == 1) drive_resp(4'b0000, '0, 1'b0, 5'd0, 1'b0);
            else end_resp();
            @(negedge clk);
        end
        end_resp();
        bus.ID_stopFetch_i = 1'b0;
        fetch(4'b0000, '0, 0, 1'b0, 5'd0, 1'b0);

        // Translation exception halts fetch until a redirect.
        fetch(4'b0000, '0, 1, 1'b1, 5'h03, 1'b1);
        expect_idle("halt_req", 3);

        // Misaligned PC: AdEL packet without any request.
        redirect(32'h8000_0102);
        check("adel_req", 128'(bus.IC_req_o), 128'd0);
        a.en = 4'b0001; a.num = 3'd1; a.base = 32'h8000_0102; a.inst = '0;
        a.take = '0; a.dest = '0; a.info = '0;
        a.exc = 1'b1; a.code = EXC_ADEL; a.refill = 1'b0;
        exp_q.push_back(a);
        expect_idle("adel_halt_req", 4);

        redirect(32'h8000_0200);
        fetch(4'b0000, '0, 1, 1'b0, 5'd0, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
